// File: rtl/chrono_ctrl.sv
// Stopwatch controller: prescaled seconds strobe, minute chaining off the seconds carry,
// start/stop/lap/clear sequencing from two buttons, lap capture and 59:59 rollover flag.
module chrono_ctrl #(
   parameter int TICK_DIV = 100000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_ss,
   input  logic       btn_lc,
   input  logic [5:0] sec_val,
   input  logic [5:0] min_val,
   input  logic       sec_carry,
   output logic       sec_pauza,
   output logic       min_pauza,
   output logic       cnt_reset,
   output logic [5:0] lap_sec,
   output logic [5:0] lap_min,
   output logic       lap_valid,
   output logic       running,
   output logic       ovf
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, STOP, CLEAR} state_t;

   state_t        state_reg, state_next;
   logic [PW-1:0] presc_reg, presc_next;
   logic          ss_q_reg, lc_q_reg, carry_q_reg;
   logic          sec_pauza_reg, min_pauza_reg, cnt_reset_reg;
   logic          cnt_reset_next;
   logic [5:0]    lap_sec_reg, lap_sec_next, lap_min_reg, lap_min_next;
   logic          lap_valid_reg, lap_valid_next;
   logic          running_reg, ovf_reg, ovf_next;
   logic          strobe, carry_evt;
   logic          ss_press, lc_press, carry_edge, rollover;

   assign ss_press   = btn_ss & ~ss_q_reg;
   assign lc_press   = btn_lc & ~lc_q_reg;
   assign carry_edge = sec_carry & ~carry_q_reg;
   assign rollover   = carry_edge && (min_val == 6'd59);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         presc_reg     <= '0;
         ss_q_reg      <= 1'b1;
         lc_q_reg      <= 1'b1;
         carry_q_reg   <= 1'b0;
         sec_pauza_reg <= 1'b1;
         min_pauza_reg <= 1'b1;
         cnt_reset_reg <= 1'b0;
         lap_sec_reg   <= '0;
         lap_min_reg   <= '0;
         lap_valid_reg <= 1'b0;
         running_reg   <= 1'b0;
         ovf_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         presc_reg     <= presc_next;
         ss_q_reg      <= btn_ss;
         lc_q_reg      <= btn_lc;
         carry_q_reg   <= sec_carry;
         sec_pauza_reg <= ~strobe;
         min_pauza_reg <= ~carry_evt;
         cnt_reset_reg <= cnt_reset_next;
         lap_sec_reg   <= lap_sec_next;
         lap_min_reg   <= lap_min_next;
         lap_valid_reg <= lap_valid_next;
         running_reg   <= (state_next == RUN);
         ovf_reg       <= ovf_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      presc_next     = presc_reg;
      strobe         = 1'b0;
      carry_evt      = 1'b0;
      cnt_reset_next = 1'b0;
      lap_sec_next   = lap_sec_reg;
      lap_min_next   = lap_min_reg;
      lap_valid_next = lap_valid_reg;
      ovf_next       = ovf_reg;
      case (state_reg)
         IDLE: begin
            if (ss_press) begin
               state_next = RUN;
               presc_next = '0;
            end
         end
         RUN: begin
            carry_evt = carry_edge;
            // Leaving RUN on this edge freezes the prescaler so no partial tick is lost.
            if (rollover) begin
               ovf_next   = 1'b1;
               state_next = STOP;
            end else if (ss_press) begin
               state_next = STOP;
            end else begin
               if (presc_reg == PRESC_MAX) begin
                  presc_next = '0;
                  strobe     = 1'b1;
               end else begin
                  presc_next = presc_reg + PW'(1);
               end
               if (lc_press) begin
                  lap_sec_next   = sec_val;
                  lap_min_next   = min_val;
                  lap_valid_next = 1'b1;
               end
            end
         end
         STOP: begin
            carry_evt = carry_edge;
            if (rollover) begin
               ovf_next = 1'b1;
            end else if (ss_press) begin
               state_next = RUN;
            end else if (lc_press) begin
               state_next     = CLEAR;
               cnt_reset_next = 1'b1;
               lap_sec_next   = '0;
               lap_min_next   = '0;
               lap_valid_next = 1'b0;
               ovf_next       = 1'b0;
               presc_next     = '0;
            end
         end
         CLEAR: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign sec_pauza = sec_pauza_reg;
   assign min_pauza = min_pauza_reg;
   assign cnt_reset = cnt_reset_reg;
   assign lap_sec   = lap_sec_reg;
   assign lap_min   = lap_min_reg;
   assign lap_valid = lap_valid_reg;
   assign running   = running_reg;
   assign ovf       = ovf_reg;

endmodule

// File: tb/tb_chrono_ctrl.sv
// Directed bench for chrono_ctrl with TICK_DIV=4 and a behavioural pair of 0..59 counters.
module tb_chrono_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       btn_ss = 1'b0;
   logic       btn_lc = 1'b0;
   logic [5:0] sec_val, min_val;
   logic       sec_carry;
   logic       sec_pauza, min_pauza, cnt_reset;
   logic [5:0] lap_sec, lap_min;
   logic       lap_valid, running, ovf;

   logic       load = 1'b0;
   logic [5:0] ld_sec = '0, ld_min = '0;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   chrono_ctrl #(.TICK_DIV(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .btn_ss    (btn_ss),
      .btn_lc    (btn_lc),
      .sec_val   (sec_val),
      .min_val   (min_val),
      .sec_carry (sec_carry),
      .sec_pauza (sec_pauza),
      .min_pauza (min_pauza),
      .cnt_reset (cnt_reset),
      .lap_sec   (lap_sec),
      .lap_min   (lap_min),
      .lap_valid (lap_valid),
      .running   (running),
      .ovf       (ovf)
   );

   // External seconds/minutes counters with a preload port for directed setup
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         sec_val   <= '0;
         min_val   <= '0;
         sec_carry <= 1'b0;
      end else if (load) begin
         sec_val   <= ld_sec;
         min_val   <= ld_min;
         sec_carry <= 1'b0;
      end else if (cnt_reset) begin
         sec_val   <= '0;
         min_val   <= '0;
         sec_carry <= 1'b0;
      end else begin
         sec_carry <= !sec_pauza && (sec_val == 6'd59);
         if (!sec_pauza) sec_val <= (sec_val == 6'd59) ? 6'd0 : sec_val + 6'd1;
         if (!min_pauza) min_val <= (min_val == 6'd59) ? 6'd0 : min_val + 6'd1;
      end
   end

   task automatic chk(input string tag, input int obs, input int exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
      $display("[TB] check %-16s observed %0d expected %0d", tag, obs, exp_v);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      // 1: reset values, start, strobe cadence
      cyc(3);
      chk("rst_sec_pauza", sec_pauza, 1);
      chk("rst_min_pauza", min_pauza, 1);
      chk("rst_cnt_reset", cnt_reset, 0);
      chk("rst_running", running, 0);
      chk("rst_lap_valid", lap_valid, 0);
      chk("rst_ovf", ovf, 0);
      reset = 1'b0;
      cyc(2);
      btn_ss = 1'b1;
      cyc(1);
      btn_ss = 1'b0;
      chk("t1_running", running, 1);
      for (int n = 1; n <= 12; n++) begin
         cyc(1);
         chk("t1_sec_pauza", sec_pauza, (n % 4 == 0) ? 0 : 1);
         if (n == 5) chk("t1_sec1", sec_val, 1);
      end
      chk("t1_sec2", sec_val, 2);
      cyc(1);
      chk("t1_sec3", sec_val, 3);

      // 2: stop mid-period, resume without losing the partial tick
      cyc(1);
      btn_ss = 1'b1;
      cyc(1);
      btn_ss = 1'b0;
      chk("t2_stopped", running, 0);
      for (int n = 0; n < 5; n++) begin
         cyc(1);
         chk("t2_no_strobe", sec_pauza, 1);
      end
      chk("t2_sec_hold", sec_val, 3);
      btn_ss = 1'b1;
      cyc(1);
      btn_ss = 1'b0;
      chk("t2_resumed", running, 1);
      cyc(1);
      chk("t2_pauza_r1", sec_pauza, 1);
      cyc(1);
      chk("t2_pauza_r2", sec_pauza, 0);
      cyc(1);
      chk("t2_sec4", sec_val, 4);

      // 3: seconds carry chains into minutes
      load = 1'b1; ld_sec = 6'd59; ld_min = 6'd0;
      cyc(1);
      load = 1'b0;
      cyc(2);
      chk("t3_strobe", sec_pauza, 0);
      cyc(1);
      chk("t3_sec_wrap", sec_val, 0);
      chk("t3_carry", sec_carry, 1);
      chk("t3_min_p_pre", min_pauza, 1);
      cyc(1);
      chk("t3_min_pulse", min_pauza, 0);
      cyc(1);
      chk("t3_min_p_post", min_pauza, 1);
      chk("t3_min1", min_val, 1);
      chk("t3_sec0", sec_val, 0);

      // 4: 59:59 rollover forces STOP, then clear
      load = 1'b1; ld_sec = 6'd59; ld_min = 6'd59;
      cyc(1);
      load = 1'b0;
      chk("t4_strobe", sec_pauza, 0);
      cyc(1);
      chk("t4_ovf_pre", ovf, 0);
      cyc(1);
      chk("t4_ovf", ovf, 1);
      chk("t4_running", running, 0);
      chk("t4_min_pulse", min_pauza, 0);
      cyc(1);
      chk("t4_min_p_post", min_pauza, 1);
      chk("t4_min_wrap", min_val, 0);
      for (int n = 0; n < 8; n++) begin
         cyc(1);
         chk("t4_no_strobe", sec_pauza, 1);
         chk("t4_no_min", min_pauza, 1);
      end
      btn_lc = 1'b1;
      cyc(1);
      btn_lc = 1'b0;
      chk("t4_cnt_reset", cnt_reset, 1);
      chk("t4_ovf_clr", ovf, 0);
      cyc(1);
      chk("t4_cnt_rst_end", cnt_reset, 0);
      chk("t4_idle", running, 0);

      // 5: lap capture, ss+lc together, clear laps
      btn_ss = 1'b1; load = 1'b1; ld_sec = 6'd17; ld_min = 6'd2;
      cyc(1);
      btn_ss = 1'b0; load = 1'b0;
      chk("t5_running", running, 1);
      btn_lc = 1'b1;
      cyc(1);
      btn_lc = 1'b0;
      chk("t5_lap_sec", lap_sec, 17);
      chk("t5_lap_min", lap_min, 2);
      chk("t5_lap_valid", lap_valid, 1);
      chk("t5_still_run", running, 1);
      cyc(4);
      chk("t5_sec18", sec_val, 18);
      btn_ss = 1'b1; btn_lc = 1'b1;
      cyc(1);
      btn_ss = 1'b0; btn_lc = 1'b0;
      chk("t5_both_stop", running, 0);
      chk("t5_lap_keep", lap_sec, 17);
      chk("t5_lapv_keep", lap_valid, 1);
      cyc(1);
      btn_lc = 1'b1;
      cyc(1);
      btn_lc = 1'b0;
      chk("t5_lap_sec_clr", lap_sec, 0);
      chk("t5_lap_min_clr", lap_min, 0);
      chk("t5_lapv_clr", lap_valid, 0);
      chk("t5_cnt_reset", cnt_reset, 1);
      cyc(1);

      // 6: button held through reset; async reset mid-run
      reset = 1'b1; btn_ss = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(3);
      chk("t6_held_ss", running, 0);
      btn_ss = 1'b0;
      cyc(1);
      btn_ss = 1'b1;
      cyc(1);
      btn_ss = 1'b0; btn_lc = 1'b1;
      cyc(1);
      btn_lc = 1'b0;
      chk("t6_pre_run", running, 1);
      chk("t6_pre_lapv", lap_valid, 1);
      #1 reset = 1'b1;
      #1;
      chk("t6_rst_running", running, 0);
      chk("t6_rst_lapv", lap_valid, 0);
      chk("t6_rst_sec_p", sec_pauza, 1);
      chk("t6_rst_min_p", min_pauza, 1);
      chk("t6_rst_cnt_rst", cnt_reset, 0);
      chk("t6_rst_ovf", ovf, 0);
      cyc(1);
      reset = 1'b0;
      cyc(1);
      btn_ss = 1'b1;
      cyc(1);
      btn_ss = 1'b0;
      for (int n = 1; n <= 4; n++) begin
         cyc(1);
         chk("t6_presc0", sec_pauza, (n == 4) ? 0 : 1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
